// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one 4x4 unsigned multiplier among NUM_REQ requesters.
// Latency: grant edge -> resp_valid next cycle; MULT_SHARE_PIPE_EN adds a registered CALC cycle.
// Backpressure: response held stable until resp_ready; no grant is issued while a response is pending.
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_a,
    input  logic [4*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   resp_valid,
    output logic [7:0]             resp_p,
    output logic [ID_W-1:0]        resp_id,
    input  logic                   resp_ready,
    output logic [15:0]            ops_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win_id;
    logic            found;
    logic [3:0]      a_q, b_q;
    logic [ID_W-1:0] id_q;
    logic [7:0]      prod;
    logic            grant, complete;

    // Requester index base+off, wrapped modulo NUM_REQ (off < NUM_REQ).
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[wrap_idx(rr_ptr, k)]) begin
                found  = 1'b1;
                win_id = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        grant      = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant             = 1'b1;
                    req_ready[win_id] = 1'b1;
`ifdef MULT_SHARE_PIPE_EN
                    state_nxt         = CALC;
`else
                    state_nxt         = RESP;
`endif
                end
            end
            CALC: state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            id_q     <= '0;
            ops_done <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                a_q    <= req_a[4*win_id +: 4];
                b_q    <= req_b[4*win_id +: 4];
                id_q   <= win_id;
                rr_ptr <= wrap_idx(win_id, 1);
            end
            if (complete) ops_done <= ops_done + 16'd1;
        end
    end

`ifdef MULT_SHARE_PIPE_EN
    logic [7:0] p_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else if (state == CALC) begin
            p_q <= {4'b0, a_q} * {4'b0, b_q};
        end
    end

    assign prod = p_q;
`else
    assign prod = {4'b0, a_q} * {4'b0, b_q};
`endif

    // Response fields read as zero whenever no response is offered.
    assign resp_p  = resp_valid ? prod : 8'd0;
    assign resp_id = resp_valid ? id_q : '0;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed cases, then random traffic against a round-robin reference model.
module tb_mult_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef MULT_SHARE_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [4*NUM_REQ-1:0] req_a, req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic [7:0]           resp_p;
    logic [ID_W-1:0]      resp_id;
    logic                 resp_ready;
    logic [15:0]          ops_done;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_p     (resp_p),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .ops_done   (ops_done)
    );

    typedef struct {
        int id;
        int p;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    bit         pv[NUM_REQ];
    logic [3:0] pa[NUM_REQ];
    logic [3:0] pb[NUM_REQ];
    bit         rdy = 1'b0;
    int         rr = 0;
    bit         busy = 1'b0;
    int         resp_start = 0;
    int         cyc = 0;
    int         exp_done = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]     = pv[i];
            req_a[4*i +: 4]  = pa[i];
            req_b[4*i +: 4]  = pb[i];
        end
        resp_ready = rdy;
    endtask

    task automatic model_reset();
        exp_q.delete();
        busy     = 1'b0;
        rr       = 0;
        exp_done = 0;
        for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check grant/valid, then advance the reference model past the edge.
    task automatic step();
        int win;
        bit grant;
        bit done;
        apply_inputs();
        #1;
        win = -1;
        if (!busy) begin
            for (int k = 0; k < NUM_REQ; k++)
                if (win < 0 && pv[(rr + k) % NUM_REQ]) win = (rr + k) % NUM_REQ;
        end
        check("req_ready", int'(req_ready), (win >= 0) ? (1 << win) : 0);
        check("resp_valid", int'(resp_valid), (busy && cyc >= resp_start) ? 1 : 0);
        check("ops_done", int'(ops_done), exp_done);
        grant = (win >= 0);
        done  = busy && (cyc >= resp_start) && rdy;
        @(posedge clk);
        if (done) begin
            busy     = 1'b0;
            exp_done = (exp_done + 1) % 65536;
        end
        if (grant) begin
            busy       = 1'b1;
            resp_start = cyc + LAT;
            exp_q.push_back('{win, int'(pa[win]) * int'(pb[win])});
            pv[win]    = 1'b0;
            rr         = (win + 1) % NUM_REQ;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Response monitor: pops the scoreboard on each accepted response, checks hold and idle values.
    bit         hold = 1'b0;
    logic [7:0] hold_p;
    int         hold_id;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
            end else if (resp_valid) begin
                if (hold) begin
                    check("hold_p", int'(resp_p), int'(hold_p));
                    check("hold_id", int'(resp_id), hold_id);
                end
                if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL resp_unexpected: got product %0d id %0d with nothing expected", resp_p, resp_id);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_p", int'(resp_p), e.p);
                        check("resp_id", int'(resp_id), e.id);
                    end
                    hold = 1'b0;
                end else begin
                    hold    = 1'b1;
                    hold_p  = resp_p;
                    hold_id = int'(resp_id);
                end
            end else begin
                check("idle_p", int'(resp_p), 0);
                check("idle_id", int'(resp_id), 0);
                hold = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
            pb[i] = '0;
        end
        rst = 1'b1;
        rdy = 1'b0;
        apply_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_p", int'(resp_p), 0);
        check("rst_ops_done", int'(ops_done), 0);
        rst = 1'b0;

        // Single request from requester 2: 12*14.
        pv[2] = 1'b1; pa[2] = 4'd12; pb[2] = 4'd14; rdy = 1'b1;
        repeat (4) step();

        // Reset while a response is being held.
        pv[1] = 1'b1; pa[1] = 4'd3; pb[1] = 4'd5; rdy = 1'b0;
        repeat (1 + LAT) step();
        #3;
        rst = 1'b1;
        #1;
        check("midrst_resp_valid", int'(resp_valid), 0);
        check("midrst_resp_p", int'(resp_p), 0);
        check("midrst_resp_id", int'(resp_id), 0);
        check("midrst_req_ready", int'(req_ready), 0);
        check("midrst_ops_done", int'(ops_done), 0);
        model_reset();
        apply_inputs();
        @(negedge clk);
        rst = 1'b0;

        // All requesters continuously valid: grants rotate 0,1,2,3,0.
        pa[0] = 4'd15; pb[0] = 4'd15;
        pa[1] = 4'd6;  pb[1] = 4'd15;
        pa[2] = 4'd8;  pb[2] = 4'd14;
        pa[3] = 4'd0;  pb[3] = 4'd13;
        rdy = 1'b1;
        repeat (5 * (1 + LAT)) begin
            for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b1;
            step();
        end
        for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
        repeat (4) step();

        // Backpressure: 5*9 held for five cycles while another request waits.
        pv[3] = 1'b1; pa[3] = 4'd5; pb[3] = 4'd9; rdy = 1'b0;
        step();
        pv[0] = 1'b1; pa[0] = 4'd7; pb[0] = 4'd2;
        repeat (4 + LAT) step();
        rdy = 1'b1;
        repeat (6) step();

        // Completion counter wrap.
        force dut.ops_done = 16'hFFFF;
        #1;
        release dut.ops_done;
        exp_done = 16'hFFFF;
        pv[1] = 1'b1; pa[1] = 4'd9; pb[1] = 4'd9;
        repeat (4) step();

        // Random traffic with random backpressure.
        repeat (3000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pb[i] = 4'($urandom_range(0, 15));
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end
        for (int i = 0; i < NUM_REQ; i++) pv[i] = 1'b0;
        rdy = 1'b1;
        repeat (8) step();
        check("drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
